mem_wb_pipe: RTL and testbench
==============================

Name: mem_wb_pipe

Overview:
Parametrised MEM/WB pipeline register and load-return stage; successor to the fixed 32-bit MEM/WB register.
- Detects misaligned accesses internally.
- Handles memory bus accesses that take several cycles via a req/rdy handshake.
- Extracts and sign/zero-extends byte, half and word loads.
- Raises a stall request to the pipeline controller while an access is in flight.
- Sits between the EX/MEM register and the writeback/control stage.

Parameters:
PC_W, 30, width of word PC
DATA_W, 32, data bus width; legal values 32 or 64
AL_W, 2, address low bits used for lane select; must equal log2(DATA_W/8)
REG_ADDR_W, 5, register address width
CTRL_OP_W, 2, control-op width; value 0 is NOP
EXP_W, 3, exception code width; value 0 is no exception
EXP_MISS_ALIGN, 3'd5, exception code for a misaligned access
BIG_ENDIAN, 1, 1: byte lane 0 is the MS byte; 0: byte lane 0 is the LS byte

Ports:
clk  in  1  clock
reset  in  1  reset; one clock; reset is asynchronous and active-low
stall  in  1  hold MEM/WB registers
flush  in  1  squash the instruction in MEM
ex_pc  in  PC_W  EX/MEM PC
ex_en  in  1  EX/MEM valid
ex_br_flag  in  1  delay-slot/branch flag
ex_ctrl_op  in  CTRL_OP_W  control op
ex_dst_addr  in  REG_ADDR_W  destination register
ex_gpr_we_  in  1  GPR write enable, active-low
ex_exp_code  in  EXP_W  upstream exception code
ex_mem_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
ex_mem_size  in  2  00 byte, 01 half, 10 word, 11 dword (dword legal only when DATA_W=64)
ex_mem_signed  in  1  sign-extend load
ex_addr_lo  in  AL_W  byte offset of the access
ex_out  in  DATA_W  ALU result for non-memory instructions
bus_req  out  1  memory access request (combinational)
bus_rdy  in  1  access complete; bus_rdata valid in the same cycle
bus_rdata  in  DATA_W  raw read word
mem_busy  out  1  stall request to the pipeline controller (combinational)
mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_gpr_we_, mem_exp_code  out  matching ex_ widths  MEM/WB registers
mem_out  out  DATA_W  writeback data

Behaviour:
- Access decode: acc = ex_en & (ex_mem_op==01 | ex_mem_op==10).
- Misalignment: mis = acc & (offset not a multiple of the size, or dword with DATA_W=32). A misaligned access never asserts bus_req.
- bus_req = acc & !mis & !flush & (state==IDLE | state==WAIT). bus_req holds high until bus_rdy is sampled.
- mem_busy = bus_req & !bus_rdy, or state==HOLD & stall.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE -> WAIT: bus_req & !bus_rdy.
  - WAIT -> IDLE: bus_rdy & !stall. Commit the instruction.
  - WAIT -> HOLD: bus_rdy & stall. Capture the extracted data into an internal holding register.
  - HOLD -> IDLE: !stall. Commit from the holding register. No second bus_req is issued.
  - Any state -> IDLE: flush. bus_req drops that cycle and MEM/WB loads a bubble. An in-flight bus_rdy arriving with flush is discarded.
- Register update priority, evaluated each posedge:
  1. reset
  2. stall (hold all registers)
  3. flush (bubble)
  4. access pending, i.e. mem_busy: bubble (mem_en=0, ctrl NOP, gpr_we_=1, exp 0, out 0)
  5. mis: pc, en and br_flag pass through; ctrl NOP; dst 0; gpr_we_=1; exp=EXP_MISS_ALIGN; out 0
  6. normal load: mem_out = extracted load data
  7. store: mem_out = 0
  8. non-memory: mem_out = ex_out
  - All other fields pass from ex_ in the normal cases (6-8).
- Load extraction:
  - Lane index = ex_addr_lo / size_bytes, ordered according to BIG_ENDIAN.
  - Selected field is sign-extended when ex_mem_signed=1, else zero-extended, to DATA_W.
  - A word load on DATA_W=32 passes bus_rdata unchanged.
- Latency: a zero-wait access (bus_rdy in the request cycle) commits at the next edge. N wait cycles give N bubbles.
- Reset values: all MEM/WB outputs 0, except mem_gpr_we_=1. State IDLE, holding register 0. bus_req and mem_busy read 0 while reset is asserted, since acc gating is forced off in reset.
- Reset asserted mid-access returns to IDLE immediately. The bus must tolerate the abandoned request.

Test Plan:
- Reset: reset=0 mid-WAIT -> all outputs 0, mem_gpr_we_=1, bus_req=0; after release the FSM is IDLE.
- Non-memory pass-through: ex_pc=30'h100, ex_out=32'h1234_5678, ex_en=1 -> next edge mem_pc=30'h100, mem_out=32'h1234_5678.
- Signed byte load, BIG_ENDIAN=1: ex_addr_lo=2, bus_rdata=32'h0011_8033, bus_rdy=1 -> mem_out=32'hFFFF_FF80. Same load with unsigned -> mem_out=32'h0000_0080.
- Misaligned half load: ex_addr_lo=1 -> bus_req=0, mem_exp_code=3'd5, mem_ctrl_op=0, mem_gpr_we_=1, mem_pc=ex_pc.
- Wait states: bus_rdy low for 3 cycles -> mem_busy=1 for 3 cycles, 3 bubbles, then a single commit with the correct data.
- Stall and flush: bus_rdy arrives while stall=1 -> HOLD, data committed when stall drops, no second bus_req. Flush during WAIT -> bus_req=0, bubble, IDLE.

Source files
------------

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with load-return stage.
// Issues bus accesses for loads and stores, waits out multi-cycle bus
// responses, extracts and extends load data, and asks the pipeline
// controller to stall while an access is outstanding.
module mem_wb_pipe #(
   parameter int              PC_W           = 30,
   parameter int              DATA_W         = 32,
   parameter int              AL_W           = 2,
   parameter int              REG_ADDR_W     = 5,
   parameter int              CTRL_OP_W      = 2,
   parameter int              EXP_W          = 3,
   parameter logic [EXP_W-1:0] EXP_MISS_ALIGN = 3'd5,
   parameter bit              BIG_ENDIAN     = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [PC_W-1:0]       ex_pc,
   input  logic                  ex_en,
   input  logic                  ex_br_flag,
   input  logic [CTRL_OP_W-1:0]  ex_ctrl_op,
   input  logic [REG_ADDR_W-1:0] ex_dst_addr,
   input  logic                  ex_gpr_we_,
   input  logic [EXP_W-1:0]      ex_exp_code,
   input  logic [1:0]            ex_mem_op,
   input  logic [1:0]            ex_mem_size,
   input  logic                  ex_mem_signed,
   input  logic [AL_W-1:0]       ex_addr_lo,
   input  logic [DATA_W-1:0]     ex_out,
   output logic                  bus_req,
   input  logic                  bus_rdy,
   input  logic [DATA_W-1:0]     bus_rdata,
   output logic                  mem_busy,
   output logic [PC_W-1:0]       mem_pc,
   output logic                  mem_en,
   output logic                  mem_br_flag,
   output logic [CTRL_OP_W-1:0]  mem_ctrl_op,
   output logic [REG_ADDR_W-1:0] mem_dst_addr,
   output logic                  mem_gpr_we_,
   output logic [EXP_W-1:0]      mem_exp_code,
   output logic [DATA_W-1:0]     mem_out
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD} state_t;

   state_t              state_q;
   logic [DATA_W-1:0]   hold_q;

   logic                acc, mis, is_load, is_store;
   logic [31:0]         off_b, size_b, shamt;
   logic [DATA_W-1:0]   shifted, mask, sign_mask, field, ext_data, ld_data;

   logic [PC_W-1:0]       mem_pc_q, mem_pc_d;
   logic                  mem_en_q, mem_en_d;
   logic                  mem_br_flag_q, mem_br_flag_d;
   logic [CTRL_OP_W-1:0]  mem_ctrl_op_q, mem_ctrl_op_d;
   logic [REG_ADDR_W-1:0] mem_dst_addr_q, mem_dst_addr_d;
   logic                  mem_gpr_we_n_q, mem_gpr_we_n_d;
   logic [EXP_W-1:0]      mem_exp_code_q, mem_exp_code_d;
   logic [DATA_W-1:0]     mem_out_q, mem_out_d;

   // Access decode; gated by reset so the bus sees no request during reset.
   assign acc      = reset & ex_en & ((ex_mem_op == 2'b01) | (ex_mem_op == 2'b10));
   assign is_load  = acc & (ex_mem_op == 2'b01);
   assign is_store = acc & (ex_mem_op == 2'b10);

   assign off_b  = 32'(ex_addr_lo);
   assign size_b = 32'd1 << ex_mem_size;
   // Misaligned when the offset is not a multiple of the size, or the size
   // is wider than the bus.
   assign mis = acc & (((off_b & (size_b - 32'd1)) != 32'd0) |
                       (size_b > 32'(DATA_W / 8)));

   // Bit position of the selected field within the bus word.
   assign shamt = BIG_ENDIAN ? (32'(DATA_W) - 32'd8 * (off_b + size_b))
                             : (32'd8 * off_b);

   assign bus_req  = acc & ~mis & ~flush & (state_q != ST_HOLD);
   assign mem_busy = (bus_req & ~bus_rdy) | ((state_q == ST_HOLD) & stall);

   // Lane extraction and sign/zero extension of the raw read word.
   always_comb begin
      shifted = bus_rdata >> shamt;
      case (ex_mem_size)
         2'b00:   mask = DATA_W'(64'h0000_0000_0000_00FF);
         2'b01:   mask = DATA_W'(64'h0000_0000_0000_FFFF);
         2'b10:   mask = DATA_W'(64'h0000_0000_FFFF_FFFF);
         default: mask = '1;
      endcase
      sign_mask = mask ^ (mask >> 1);
      field     = shifted & mask;
      ext_data  = (ex_mem_signed && ((shifted & sign_mask) != '0)) ? (field | ~mask) : field;
   end

   // Once the response has been parked, the bus word is no longer valid.
   assign ld_data = (state_q == ST_HOLD) ? hold_q : ext_data;

   // Access sequencer: tracks an outstanding access and parks returned data
   // while the pipeline is stalled. A response that arrives in the request
   // cycle under stall is parked too, so the access is never issued twice.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
      end else if (flush) begin
         state_q <= ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus_req && !bus_rdy) begin
                  state_q <= ST_WAIT;
               end else if (bus_req && bus_rdy && stall) begin
                  state_q <= ST_HOLD;
                  hold_q  <= ext_data;
               end
            end
            ST_WAIT: begin
               if (!bus_req) begin
                  state_q <= ST_IDLE;
               end else if (bus_rdy) begin
                  if (stall) begin
                     state_q <= ST_HOLD;
                     hold_q  <= ext_data;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            ST_HOLD: begin
               if (!stall) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Next MEM/WB contents: hold, bubble, misalign trap or normal commit.
   always_comb begin
      mem_pc_d       = mem_pc_q;
      mem_en_d       = mem_en_q;
      mem_br_flag_d  = mem_br_flag_q;
      mem_ctrl_op_d  = mem_ctrl_op_q;
      mem_dst_addr_d = mem_dst_addr_q;
      mem_gpr_we_n_d = mem_gpr_we_n_q;
      mem_exp_code_d = mem_exp_code_q;
      mem_out_d      = mem_out_q;
      if (stall) begin
         // keep everything
      end else if (flush || mem_busy) begin
         mem_pc_d       = '0;
         mem_en_d       = 1'b0;
         mem_br_flag_d  = 1'b0;
         mem_ctrl_op_d  = '0;
         mem_dst_addr_d = '0;
         mem_gpr_we_n_d = 1'b1;
         mem_exp_code_d = '0;
         mem_out_d      = '0;
      end else if (mis) begin
         mem_pc_d       = ex_pc;
         mem_en_d       = ex_en;
         mem_br_flag_d  = ex_br_flag;
         mem_ctrl_op_d  = '0;
         mem_dst_addr_d = '0;
         mem_gpr_we_n_d = 1'b1;
         mem_exp_code_d = EXP_MISS_ALIGN;
         mem_out_d      = '0;
      end else begin
         mem_pc_d       = ex_pc;
         mem_en_d       = ex_en;
         mem_br_flag_d  = ex_br_flag;
         mem_ctrl_op_d  = ex_ctrl_op;
         mem_dst_addr_d = ex_dst_addr;
         mem_gpr_we_n_d = ex_gpr_we_;
         mem_exp_code_d = ex_exp_code;
         if (is_load)       mem_out_d = ld_data;
         else if (is_store) mem_out_d = '0;
         else               mem_out_d = ex_out;
      end
   end

   // MEM/WB register bank.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_pc_q       <= '0;
         mem_en_q       <= 1'b0;
         mem_br_flag_q  <= 1'b0;
         mem_ctrl_op_q  <= '0;
         mem_dst_addr_q <= '0;
         mem_gpr_we_n_q <= 1'b1;
         mem_exp_code_q <= '0;
         mem_out_q      <= '0;
      end else begin
         mem_pc_q       <= mem_pc_d;
         mem_en_q       <= mem_en_d;
         mem_br_flag_q  <= mem_br_flag_d;
         mem_ctrl_op_q  <= mem_ctrl_op_d;
         mem_dst_addr_q <= mem_dst_addr_d;
         mem_gpr_we_n_q <= mem_gpr_we_n_d;
         mem_exp_code_q <= mem_exp_code_d;
         mem_out_q      <= mem_out_d;
      end
   end

   assign mem_pc       = mem_pc_q;
   assign mem_en       = mem_en_q;
   assign mem_br_flag  = mem_br_flag_q;
   assign mem_ctrl_op  = mem_ctrl_op_q;
   assign mem_dst_addr = mem_dst_addr_q;
   assign mem_gpr_we_  = mem_gpr_we_n_q;
   assign mem_exp_code = mem_exp_code_q;
   assign mem_out      = mem_out_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe (DATA_W=32, big-endian): directed stimulus, a
// transaction-level reference model checked every cycle, and a few
// hand-computed literal expectations.
module tb_mem_wb_pipe;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall, flush;
   logic [29:0] ex_pc;
   logic        ex_en, ex_br_flag;
   logic [1:0]  ex_ctrl_op;
   logic [4:0]  ex_dst_addr;
   logic        ex_gpr_we_;
   logic [2:0]  ex_exp_code;
   logic [1:0]  ex_mem_op, ex_mem_size;
   logic        ex_mem_signed;
   logic [1:0]  ex_addr_lo;
   logic [31:0] ex_out;
   logic        bus_req, bus_rdy, mem_busy;
   logic [31:0] bus_rdata;
   logic [29:0] mem_pc;
   logic        mem_en, mem_br_flag;
   logic [1:0]  mem_ctrl_op;
   logic [4:0]  mem_dst_addr;
   logic        mem_gpr_we_;
   logic [2:0]  mem_exp_code;
   logic [31:0] mem_out;

   mem_wb_pipe dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag),
      .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
      .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code),
      .ex_mem_op(ex_mem_op), .ex_mem_size(ex_mem_size),
      .ex_mem_signed(ex_mem_signed), .ex_addr_lo(ex_addr_lo),
      .ex_out(ex_out), .bus_req(bus_req), .bus_rdy(bus_rdy),
      .bus_rdata(bus_rdata), .mem_busy(mem_busy),
      .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag),
      .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr),
      .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code),
      .mem_out(mem_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // literal expectations requested by the stimulus for the next edge
   logic        lit_on = 1'b0, lit_pc_on = 1'b0;
   logic        lit_en, lit_we;
   logic [29:0] lit_pc;
   logic [31:0] lit_out;
   logic [2:0]  lit_exp;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Big-endian reference extraction: lane 0 is the most significant byte.
   function automatic logic [31:0] m_extract(logic [31:0] w, int off, int sb, logic sgn);
      logic [63:0] v;
      logic [7:0]  b;
      v = 64'd0;
      for (int k = 0; k < sb; k++) begin
         b = w[31 - 8 * (off + k) -: 8];
         v = (v << 8) | {56'd0, b};
      end
      if (sgn && sb < 4 && v[8 * sb - 1]) v = v | ~((64'd1 << (8 * sb)) - 64'd1);
      return v[31:0];
   endfunction

   // model state: has the current access already returned data, and what
   logic        m_cap;
   logic [31:0] m_held;
   logic [29:0] e_pc;
   logic        e_en, e_br, e_we;
   logic [1:0]  e_ctrl;
   logic [4:0]  e_dst;
   logic [2:0]  e_exp;
   logic [31:0] e_out, m_d;
   logic        m_acc, m_mis, m_req, m_busy;
   int          m_sb, m_off;

   task automatic check_regs(input string tag);
      chk({tag, ".mem_pc"}, 64'(mem_pc), 64'(e_pc));
      chk({tag, ".mem_en"}, 64'(mem_en), 64'(e_en));
      chk({tag, ".mem_br_flag"}, 64'(mem_br_flag), 64'(e_br));
      chk({tag, ".mem_ctrl_op"}, 64'(mem_ctrl_op), 64'(e_ctrl));
      chk({tag, ".mem_dst_addr"}, 64'(mem_dst_addr), 64'(e_dst));
      chk({tag, ".mem_gpr_we_"}, 64'(mem_gpr_we_), 64'(e_we));
      chk({tag, ".mem_exp_code"}, 64'(mem_exp_code), 64'(e_exp));
      chk({tag, ".mem_out"}, 64'(mem_out), 64'(e_out));
   endtask

   // Single compare process: reference model plus literal checks.
   always begin : compare
      @(posedge clk or negedge reset);
      if (!reset) begin
         #1;
         m_cap = 1'b0; m_held = '0;
         e_pc = '0; e_en = 0; e_br = 0; e_ctrl = '0; e_dst = '0;
         e_we = 1'b1; e_exp = '0; e_out = '0;
         chk("reset.bus_req", 64'(bus_req), 64'd0);
         chk("reset.mem_busy", 64'(mem_busy), 64'd0);
         check_regs("reset");
      end else begin
         m_acc  = ex_en && (ex_mem_op == 2'b01 || ex_mem_op == 2'b10);
         m_sb   = 1 << ex_mem_size;
         m_off  = int'(ex_addr_lo);
         m_mis  = m_acc && ((m_off % m_sb) != 0 || m_sb > 4);
         m_req  = m_acc && !m_mis && !flush && !m_cap;
         m_busy = (m_req && !bus_rdy) || (m_cap && stall);
         chk("bus_req", 64'(bus_req), 64'(m_req));
         chk("mem_busy", 64'(mem_busy), 64'(m_busy));
         if (m_cap)                m_d = m_held;
         else if (m_acc && !m_mis) m_d = m_extract(bus_rdata, m_off, m_sb, ex_mem_signed);
         else                      m_d = '0;
         if (!stall) begin
            if (flush || m_busy) begin
               e_pc = '0; e_en = 0; e_br = 0; e_ctrl = '0; e_dst = '0;
               e_we = 1'b1; e_exp = '0; e_out = '0;
            end else if (m_mis) begin
               e_pc = ex_pc; e_en = ex_en; e_br = ex_br_flag; e_ctrl = '0;
               e_dst = '0; e_we = 1'b1; e_exp = 3'd5; e_out = '0;
            end else begin
               e_pc = ex_pc; e_en = ex_en; e_br = ex_br_flag; e_ctrl = ex_ctrl_op;
               e_dst = ex_dst_addr; e_we = ex_gpr_we_; e_exp = ex_exp_code;
               if (m_acc && ex_mem_op == 2'b01)      e_out = m_d;
               else if (m_acc && ex_mem_op == 2'b10) e_out = '0;
               else                                  e_out = ex_out;
            end
         end
         if (flush) m_cap = 1'b0;
         else if (m_cap) begin
            if (!stall) m_cap = 1'b0;
         end else if (m_req && bus_rdy && stall) begin
            m_cap = 1'b1;
            m_held = m_d;
         end
         #1;
         check_regs("cycle");
         if (lit_on) begin
            chk("lit.mem_en", 64'(mem_en), 64'(lit_en));
            chk("lit.mem_out", 64'(mem_out), 64'(lit_out));
            chk("lit.mem_exp_code", 64'(mem_exp_code), 64'(lit_exp));
            chk("lit.mem_gpr_we_", 64'(mem_gpr_we_), 64'(lit_we));
            if (lit_pc_on) chk("lit.mem_pc", 64'(mem_pc), 64'(lit_pc));
         end
      end
   end

   task automatic step();
      @(negedge clk);
      lit_on = 1'b0; lit_pc_on = 1'b0;
   endtask

   task automatic nop();
      ex_en = 0; ex_mem_op = 2'b00; ex_mem_size = 2'b00; ex_mem_signed = 0;
      ex_addr_lo = 2'd0; bus_rdy = 0; stall = 0; flush = 0;
   endtask

   task automatic mem(input logic [29:0] pc, input logic [1:0] op, input logic [1:0] sz,
                      input logic [1:0] lo, input logic sgn);
      ex_en = 1; ex_pc = pc; ex_mem_op = op; ex_mem_size = sz; ex_addr_lo = lo;
      ex_mem_signed = sgn; ex_gpr_we_ = (op == 2'b01) ? 1'b0 : 1'b1;
      ex_ctrl_op = 2'd2; ex_dst_addr = 5'd9; ex_br_flag = 1'b1; ex_exp_code = '0;
   endtask

   task automatic lit(input logic en, input logic [31:0] out, input logic [2:0] exp,
                      input logic we, input logic pc_on, input logic [29:0] pc);
      lit_on = 1'b1; lit_en = en; lit_out = out; lit_exp = exp; lit_we = we;
      lit_pc_on = pc_on; lit_pc = pc;
   endtask

   initial begin
      stall = 0; flush = 0; ex_pc = '0; ex_en = 0; ex_br_flag = 0; ex_ctrl_op = '0;
      ex_dst_addr = '0; ex_gpr_we_ = 1; ex_exp_code = '0; ex_mem_op = '0;
      ex_mem_size = '0; ex_mem_signed = 0; ex_addr_lo = '0; ex_out = '0;
      bus_rdy = 0; bus_rdata = '0;
      step(); step();
      reset = 1'b1;

      // non-memory pass-through
      step(); nop(); ex_en = 1; ex_pc = 30'h100; ex_out = 32'h1234_5678;
      ex_ctrl_op = 2'd1; ex_dst_addr = 5'd7; ex_gpr_we_ = 0; ex_br_flag = 0; ex_exp_code = 3'd2;
      lit(1, 32'h1234_5678, 3'd2, 0, 1, 30'h100);

      // zero-wait loads: signed/unsigned byte, half, word; then a store
      step(); nop(); mem(30'h101, 2'b01, 2'b00, 2'd2, 1); bus_rdata = 32'h0011_8033; bus_rdy = 1;
      lit(1, 32'hFFFF_FF80, 3'd0, 0, 1, 30'h101);
      step(); nop(); mem(30'h102, 2'b01, 2'b00, 2'd2, 0); bus_rdata = 32'h0011_8033; bus_rdy = 1;
      lit(1, 32'h0000_0080, 3'd0, 0, 1, 30'h102);
      step(); nop(); mem(30'h103, 2'b01, 2'b01, 2'd2, 1); bus_rdata = 32'h1234_F00D; bus_rdy = 1;
      lit(1, 32'hFFFF_F00D, 3'd0, 0, 0, '0);
      step(); nop(); mem(30'h104, 2'b01, 2'b10, 2'd0, 1); bus_rdata = 32'h89AB_CDEF; bus_rdy = 1;
      lit(1, 32'h89AB_CDEF, 3'd0, 0, 0, '0);
      step(); nop(); mem(30'h105, 2'b10, 2'b10, 2'd0, 0); bus_rdata = 32'h5555_5555; bus_rdy = 1;
      ex_out = 32'hDEAD_0000; lit(1, 32'h0, 3'd0, 1, 0, '0);

      // invalid instruction carrying a load: no request
      step(); nop(); mem(30'h106, 2'b01, 2'b10, 2'd0, 0); ex_en = 0; ex_out = 32'h0000_0A0A;

      // misaligned half load
      step(); nop(); mem(30'h1A0, 2'b01, 2'b01, 2'd1, 1);
      lit(1, 32'h0, 3'd5, 1, 1, 30'h1A0);
      step(); nop(); mem(30'h1A1, 2'b01, 2'b11, 2'd0, 0);

      // three wait states then commit
      step(); nop(); mem(30'h200, 2'b01, 2'b10, 2'd0, 0);
      step(); step();
      step(); bus_rdy = 1; bus_rdata = 32'hCAFE_BABE;
      lit(1, 32'hCAFE_BABE, 3'd0, 0, 1, 30'h200);
      step(); nop();

      // response under stall is parked and committed once stall drops
      step(); nop(); mem(30'h300, 2'b01, 2'b01, 2'd0, 1);
      step(); bus_rdy = 1; bus_rdata = 32'h8001_7777; stall = 1;
      step(); bus_rdy = 0; bus_rdata = 32'h0;
      step(); stall = 0;
      lit(1, 32'hFFFF_8001, 3'd0, 0, 1, 30'h300);
      step(); nop();

      // flush during wait
      step(); nop(); mem(30'h400, 2'b01, 2'b10, 2'd0, 0);
      step(); flush = 1; bus_rdy = 1; bus_rdata = 32'h1111_2222;
      lit(0, 32'h0, 3'd0, 1, 0, '0);
      step(); nop();

      // reset asserted in the middle of a wait
      step(); nop(); mem(30'h600, 2'b01, 2'b10, 2'd0, 0);
      step();
      #2 reset = 1'b0;
      step();
      step(); reset = 1'b1; nop();
      step(); nop(); ex_en = 1; ex_pc = 30'h700; ex_out = 32'h0F0F_0F0F;
      ex_gpr_we_ = 0; ex_exp_code = '0;
      lit(1, 32'h0F0F_0F0F, 3'd0, 0, 1, 30'h700);
      step(); nop();
      step(); step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
